// File: rtl/register_file_pkg.sv
// Shared types and helpers for the register file: clear-engine state encoding and id qualification.
package register_file_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StClear = 1'b1
    } clear_state_e;

    // An id names real storage only when it is nonzero and below the implemented count.
    function automatic logic id_is_live(input logic [31:0] id, input int unsigned reg_count);
        return (id != 32'd0) && (id < reg_count);
    endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: storage lookup, optional write bypass, and scoreboard bit.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned REG_COUNT  = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned BYPASS     = 1
) (
    input  logic [DATA_WIDTH-1:0] storage [REG_COUNT],
    input  logic [REG_COUNT-1:0]  pending_vec,
    input  logic                  bypass_enable,
    input  logic [ADDR_WIDTH-1:0] write_id,
    input  logic [DATA_WIDTH-1:0] write_value,
    input  logic [ADDR_WIDTH-1:0] id,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  is_pending
);

    logic live;

    always_comb begin
        live       = id_is_live(32'(id), REG_COUNT);
        value      = '0;
        is_pending = 1'b0;
        if (live) begin
            value      = storage[id];
            is_pending = pending_vec[id];
            // Pending is deliberately not bypassed; only data forwards.
            if ((BYPASS != 0) && bypass_enable && (write_id == id)) begin
                value = write_value;
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Parametrised register file with two read ports, one write port, pending scoreboard
// and a sequential bulk-clear engine.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned REG_COUNT  = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read1_id,
    output logic [DATA_WIDTH-1:0] read1_value,
    output logic                  read1_pending,
    input  logic [ADDR_WIDTH-1:0] read2_id,
    output logic [DATA_WIDTH-1:0] read2_value,
    output logic                  read2_pending,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_id,
    input  logic [DATA_WIDTH-1:0] write_value,
    input  logic                  reserve_enable,
    input  logic [ADDR_WIDTH-1:0] reserve_id,
    input  logic                  clear_request,
    output logic                  clear_busy
);

    localparam logic [ADDR_WIDTH-1:0] FirstIdx = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(REG_COUNT - 1);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]  pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    clear_state_e          state_q, state_d;
    logic                  idle;

    assign idle = (state_q == StIdle);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (clear_request) state_d = StClear;
            StClear: if (idx_q == LastIdx) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        clear_busy = (state_q == StClear);
    end

    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        if (idle) begin
            if (write_enable && id_is_live(32'(write_id), REG_COUNT)) begin
                regs_d[write_id]    = write_value;
                pending_d[write_id] = 1'b0;
            end
            // Applied after the write so a new producer's reservation wins.
            if (reserve_enable && id_is_live(32'(reserve_id), REG_COUNT)) begin
                pending_d[reserve_id] = 1'b1;
            end
        end else begin
            regs_d[idx_q]    = '0;
            pending_d[idx_q] = 1'b0;
            idx_d            = (idx_q == LastIdx) ? FirstIdx : idx_q + FirstIdx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            idx_q     <= FirstIdx;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
        end
    end

    register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_read1 (
        .storage       (regs_q),
        .pending_vec   (pending_q),
        .bypass_enable (write_enable && idle),
        .write_id      (write_id),
        .write_value   (write_value),
        .id            (read1_id),
        .value         (read1_value),
        .is_pending    (read1_pending)
    );

    register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_read2 (
        .storage       (regs_q),
        .pending_vec   (pending_q),
        .bypass_enable (write_enable && idle),
        .write_id      (write_id),
        .write_value   (write_value),
        .id            (read2_id),
        .value         (read2_value),
        .is_pending    (read2_pending)
    );

endmodule
